// File: rtl/mem_subsys.sv
// ---------------------------------------------------------------------------
// mem_subsys -- small memory subsystem behind a multicycle core's memory port
//
// Purpose:
//   Decodes the core's byte address into a word-addressed RAM, a GPIO output
//   register, a 4-entry debug TX FIFO with a read-only status word, and an
//   optional free-running cycle counter.
//   Reads are combinational; all state changes on the rising edge of clk.
//
// Address map:
//   0x0xxxxxxx  RAM, word index address[RAM_AW+1:2]
//   0xF0000000  GPIO    (R/W, low 8 bits)
//   0xF0000004  TXDATA  (W: push into FIFO, R: 0)
//   0xF0000008  STATUS  (R: {overflow, count[2:0], empty, full})
//   0xF000000C  CYCLE   (R: counter, W: clear to 0)
//   everything else is unmapped: reads 0, writes ignored
//
// Configuration:
//   MEM_SUBSYS_CYCLE_COUNTER_EN  defined   -> CYCLE counts every clock,
//                                             writes clear it
//                                undefined -> no counter, CYCLE reads 0
//
// Ports:
//   clk            in   single clock
//   nrst           in   asynchronous active-low reset
//   MemRead        in   core read strobe
//   MemWrite       in   core write strobe
//   address[31:0]  in   core byte address
//   wdata[31:0]    in   core store data
//   rdata[31:0]    out  read data (combinational)
//   gpio_out[7:0]  out  GPIO output register
//   tx_data[31:0]  out  FIFO head word, 0 when empty
//   tx_valid       out  FIFO not empty
//   tx_ready       in   sink accepts the head word this cycle
//   err_misaligned out  sticky misaligned-access flag
// ---------------------------------------------------------------------------
module mem_subsys #(
    parameter int RAM_AW = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  gpio_out,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err_misaligned
);

    localparam int          RAM_DEPTH  = 2 ** RAM_AW;
    localparam logic [27:0] MMIO_BASE  = 28'hF00_0000;
    localparam logic [1:0]  REG_GPIO   = 2'd0;
    localparam logic [1:0]  REG_TXDATA = 2'd1;
    localparam logic [1:0]  REG_STATUS = 2'd2;
    localparam logic [1:0]  REG_CYCLE  = 2'd3;
    localparam logic [2:0]  FIFO_DEPTH = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       ram_r [0:RAM_DEPTH-1];
    logic [7:0]        gpio_r;
    logic              err_misaligned_r;
    logic [31:0]       fifo_mem_r [0:3];
    logic [1:0]        wr_ptr_r;
    logic [1:0]        rd_ptr_r;
    logic [2:0]        count_r;
    logic              overflow_r;

    // ------------------------------------------------------------------
    // Decode / control signals
    // ------------------------------------------------------------------
    logic              aligned_s;
    logic              ram_sel_s;
    logic              mmio_sel_s;
    logic [1:0]        reg_idx_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              wr_ok_s;
    logic              ram_we_s;
    logic              gpio_we_s;
    logic              push_s;
    logic              pop_s;
    logic              push_acc_s;
    logic              overflow_set_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [31:0]       status_s;
    logic [31:0]       cycle_s;
    logic [31:0]       rdata_s;

    // Address decode and write enables; misaligned accesses never write.
    always_comb begin
        aligned_s  = (address[1:0] == 2'b00);
        ram_sel_s  = (address[31:28] == 4'h0);
        mmio_sel_s = (address[31:4] == MMIO_BASE);
        reg_idx_s  = address[3:2];
        ram_idx_s  = address[RAM_AW+1:2];
        wr_ok_s    = MemWrite && aligned_s;
        ram_we_s   = wr_ok_s && ram_sel_s;
        gpio_we_s  = wr_ok_s && mmio_sel_s && (reg_idx_s == REG_GPIO);
        push_s     = wr_ok_s && mmio_sel_s && (reg_idx_s == REG_TXDATA);
    end

    // FIFO occupancy flags and push/pop qualification.
    always_comb begin
        fifo_full_s    = (count_r == FIFO_DEPTH);
        fifo_empty_s   = (count_r == 3'd0);
        pop_s          = (!fifo_empty_s) && tx_ready;
        // A push into a full FIFO only lands if the head leaves in the same
        // edge; otherwise the word is dropped and overflow latches.
        push_acc_s     = push_s && ((!fifo_full_s) || pop_s);
        overflow_set_s = push_s && fifo_full_s && (!pop_s);
        status_s       = {26'd0, overflow_r, count_r, fifo_empty_s, fifo_full_s};
    end

    // RAM array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= wdata;
        end
    end

    // GPIO output register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gpio_r <= 8'h00;
        end else if (gpio_we_s) begin
            gpio_r <= wdata[7:0];
        end
    end

    // Sticky misaligned-access flag, cleared only by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_misaligned_r <= 1'b0;
        end else if ((MemRead || MemWrite) && !aligned_s) begin
            err_misaligned_r <= 1'b1;
        end
    end

    // FIFO storage; never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            fifo_mem_r[wr_ptr_r] <= wdata;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            count_r    <= 3'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_acc_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef MEM_SUBSYS_CYCLE_COUNTER_EN
    logic [31:0] cycle_r;
    logic        cycle_we_s;

    // CYCLE register write strobe.
    always_comb begin
        cycle_we_s = wr_ok_s && mmio_sel_s && (reg_idx_s == REG_CYCLE);
    end

    // Free-running cycle counter; a software write clears it and wins over
    // the increment. Natural 32-bit wrap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cycle_r <= 32'd0;
        end else if (cycle_we_s) begin
            cycle_r <= 32'd0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Counter value presented on the read path.
    always_comb begin
        cycle_s = cycle_r;
    end
`else
    // No counter built: CYCLE reads as zero.
    always_comb begin
        cycle_s = 32'd0;
    end
`endif

    // Combinational read mux; RAM reads see the pre-write contents because
    // the array only updates on the edge.
    always_comb begin
        rdata_s = 32'd0;
        if (MemRead) begin
            if (ram_sel_s) begin
                rdata_s = ram_r[ram_idx_s];
            end else if (mmio_sel_s) begin
                case (reg_idx_s)
                    REG_GPIO:   rdata_s = {24'd0, gpio_r};
                    REG_TXDATA: rdata_s = 32'd0;
                    REG_STATUS: rdata_s = status_s;
                    REG_CYCLE:  rdata_s = cycle_s;
                    default:    rdata_s = 32'd0;
                endcase
            end else begin
                rdata_s = 32'd0;
            end
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata          = rdata_s;
    assign gpio_out       = gpio_r;
    assign err_misaligned = err_misaligned_r;
    assign tx_valid       = !fifo_empty_s;
    assign tx_data        = fifo_empty_s ? 32'd0 : fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_mem_subsys.sv
// ---------------------------------------------------------------------------
// tb_mem_subsys -- directed self-checking bench for mem_subsys.
// Inputs change 1 time unit after a rising edge; outputs are checked before
// the next rising edge.
// ---------------------------------------------------------------------------
module tb_mem_subsys;

    logic        clk;
    logic        nrst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  gpio_out;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err_misaligned;

    int total;
    int bad;

    localparam logic [31:0] A_GPIO   = 32'hF000_0000;
    localparam logic [31:0] A_TXDATA = 32'hF000_0004;
    localparam logic [31:0] A_STATUS = 32'hF000_0008;
    localparam logic [31:0] A_CYCLE  = 32'hF000_000C;

    mem_subsys #(.RAM_AW(8)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .address        (address),
        .wdata          (wdata),
        .rdata          (rdata),
        .gpio_out       (gpio_out),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .err_misaligned (err_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        address  = a;
        wdata    = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        address  = 32'd0;
        wdata    = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1;
        address = a;
        #1;
        chk(tag, rdata, exp);
        MemRead = 1'b0;
        address = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nrst     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        address  = 32'd0;
        wdata    = 32'd0;
        tx_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_gpio",     {24'd0, gpio_out},      32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid},      32'h0);
        chk("rst_tx_data",  tx_data,                32'h0);
        chk("rst_err",      {31'd0, err_misaligned}, 32'h0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        rd_chk("rst_status", A_STATUS, 32'h0000_0002);

        // RAM write then read
        tick();
        do_wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);

        // Same-cycle read and write returns pre-write data
        tick();
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        address  = 32'h0000_0010;
        wdata    = 32'h1234_5678;
        #1;
        chk("rw_same_cycle", rdata, 32'hDEAD_BEEF);
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        rd_chk("rw_after", 32'h0000_0010, 32'h1234_5678);

        // rdata is 0 with MemRead low and for unmapped addresses
        address = 32'h0000_0010;
        #1;
        chk("rd_idle_zero", rdata, 32'h0);
        rd_chk("rd_unmapped", 32'h1000_0010, 32'h0);

        // GPIO
        tick();
        do_wr(A_GPIO, 32'h1234_56A5);
        chk("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
        rd_chk("gpio_rd", A_GPIO, 32'h0000_00A5);
        chk("err_clean", {31'd0, err_misaligned}, 32'h0);

        // Misaligned write is suppressed and flagged
        tick();
        do_wr(32'h0000_0012, 32'hFFFF_FFFF);
        chk("err_set", {31'd0, err_misaligned}, 32'h1);
        rd_chk("misal_nowrite", 32'h0000_0010, 32'h1234_5678);
        rd_chk("misal_rd_aligned", 32'h0000_0013, 32'h1234_5678);

        // Unmapped and read-only writes have no effect
        tick();
        do_wr(32'h2000_0010, 32'h0000_0001);
        rd_chk("unmapped_wr", 32'h0000_0010, 32'h1234_5678);
        tick();
        do_wr(A_STATUS, 32'hFFFF_FFFF);
        rd_chk("status_ro", A_STATUS, 32'h0000_0002);

        // Reset pulse clears GPIO and error flag, RAM retained
        tick();
        nrst = 1'b0;
        #1;
        chk("rst2_gpio", {24'd0, gpio_out}, 32'h0);
        chk("rst2_err",  {31'd0, err_misaligned}, 32'h0);
        #1;
        nrst = 1'b1;
        rd_chk("ram_kept", 32'h0000_0010, 32'h1234_5678);

        // FIFO: push latency, fill, overflow
        tick();
        MemWrite = 1'b1;
        address  = A_TXDATA;
        wdata    = 32'd1;
        #1;
        chk("push_no_bypass_valid", {31'd0, tx_valid}, 32'h0);
        chk("push_no_bypass_data",  tx_data, 32'h0);
        tick();
        MemWrite = 1'b0;
        address  = 32'd0;
        chk("push1_valid", {31'd0, tx_valid}, 32'h1);
        chk("push1_data",  tx_data, 32'd1);
        rd_chk("txdata_rd_zero", A_TXDATA, 32'h0);
        do_wr(A_TXDATA, 32'd2);
        do_wr(A_TXDATA, 32'd3);
        do_wr(A_TXDATA, 32'd4);
        rd_chk("status_full", A_STATUS, 32'h0000_0011);
        do_wr(A_TXDATA, 32'd5);
        rd_chk("status_ovf", A_STATUS, 32'h0000_0031);

        // Drain: 1,2,3,4 then empty
        tx_ready = 1'b1;
        chk("drain_1", tx_data, 32'd1);
        tick();
        chk("drain_2", tx_data, 32'd2);
        tick();
        chk("drain_3", tx_data, 32'd3);
        tick();
        chk("drain_4", tx_data, 32'd4);
        tick();
        chk("drain_empty_valid", {31'd0, tx_valid}, 32'h0);
        chk("drain_empty_data",  tx_data, 32'h0);
        tx_ready = 1'b0;
        rd_chk("status_empty_ovf", A_STATUS, 32'h0000_0022);

        // Push and pop in the same cycle while full
        tick();
        do_wr(A_TXDATA, 32'd5);
        do_wr(A_TXDATA, 32'd6);
        do_wr(A_TXDATA, 32'd7);
        do_wr(A_TXDATA, 32'd8);
        rd_chk("refill_full", A_STATUS, 32'h0000_0031);
        tx_ready = 1'b1;
        do_wr(A_TXDATA, 32'd9);
        rd_chk("pushpop_count4", A_STATUS, 32'h0000_0031);
        chk("pp_6", tx_data, 32'd6);
        tick();
        chk("pp_7", tx_data, 32'd7);
        tick();
        chk("pp_8", tx_data, 32'd8);
        tick();
        chk("pp_9", tx_data, 32'd9);
        tick();
        chk("pp_empty", {31'd0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Reset in the middle of a drain discards everything
        tick();
        do_wr(A_TXDATA, 32'h0000_000A);
        do_wr(A_TXDATA, 32'h0000_000B);
        tx_ready = 1'b1;
        tick();
        nrst = 1'b0;
        #1;
        chk("rst_drain_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_drain_data",  tx_data, 32'h0);
        #1;
        nrst = 1'b1;
        tx_ready = 1'b0;
        rd_chk("rst_drain_status", A_STATUS, 32'h0000_0002);

        // Cycle counter
        tick();
`ifdef MEM_SUBSYS_CYCLE_COUNTER_EN
        do_wr(A_CYCLE, 32'h0000_0000);
        repeat (10) @(posedge clk);
        #1;
        rd_chk("cycle_10", A_CYCLE, 32'd10);
        tick();
        dut.cycle_r = 32'hFFFF_FFFF;
        #1;
        rd_chk("cycle_preset", A_CYCLE, 32'hFFFF_FFFF);
        tick();
        rd_chk("cycle_wrap", A_CYCLE, 32'h0);
`else
        do_wr(A_CYCLE, 32'h0000_0000);
        repeat (10) @(posedge clk);
        #1;
        rd_chk("cycle_off_a", A_CYCLE, 32'h0);
        do_wr(A_CYCLE, 32'h0000_0055);
        rd_chk("cycle_off_b", A_CYCLE, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_subsys.md
MEM_SUBSYS -- requirements
Module: mem_subsys

Interface
REQ-001 Parameter: RAM_AW, default 8, log2 of RAM depth in 32-bit words (256 words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 MemRead  input  1  core read strobe.
REQ-005 MemWrite  input  1  core write strobe.
REQ-006 address  input  32  core byte address.
REQ-007 wdata  input  32  core store data (core register-B output).
REQ-008 rdata  output  32  read data to core IR/MDR inputs.
REQ-009 gpio_out  output  8  GPIO output register.
REQ-010 tx_data  output  32  debug FIFO head word.
REQ-011 tx_valid  output  1  FIFO not empty.
REQ-012 tx_ready  input  1  sink accepts head word this cycle.
REQ-013 err_misaligned  output  1  sticky misaligned-access flag.

Function
REQ-014 Decode: address[31:28]=0x0 selects RAM, word index address[RAM_AW+1:2]; address[31:4]=0xF000000 selects MMIO; all other addresses are unmapped.
REQ-015 Reads are combinational: rdata reflects the selected word in the same cycle MemRead is high; rdata = 0 when MemRead is low or the address is unmapped.
REQ-016 Writes commit on the rising edge with MemWrite high; a same-cycle read of the written location returns the pre-write value.
REQ-017 MemRead and MemWrite both high: write performed, rdata returns pre-write contents.
REQ-018 MMIO 0xF0000000 GPIO: read returns {24'b0, gpio_out}; write loads wdata[7:0].
REQ-019 MMIO 0xF0000004 TXDATA: write pushes wdata into a 4-entry FIFO; read returns 0.
REQ-020 MMIO 0xF0000008 STATUS (read-only): bit0 full, bit1 empty, bits[4:2] count (0-4), bit5 sticky overflow, other bits 0.
REQ-021 MMIO 0xF000000C CYCLE: 32-bit cycle counter, behaviour per REQ-030/031.
REQ-022 FIFO pop occurs on a rising edge with tx_valid and tx_ready both high; tx_data = head entry, tx_data = 0 when empty.
REQ-023 Push while full with no same-cycle pop: word dropped, overflow bit set, FIFO unchanged.
REQ-024 Push while full with same-cycle pop: both occur, count stays 4, order preserved.
REQ-025 Push while empty: tx_valid rises the following cycle (one-cycle latency); no write-through bypass.
REQ-026 Pointer wrap-around after entry 3 is seamless; FIFO order is strictly first-in-first-out.
REQ-027 Misaligned access (address[1:0] != 0 with MemRead or MemWrite high): write suppressed; read returns the aligned word; err_misaligned set on the next edge.
REQ-028 Writes to unmapped or read-only addresses are ignored with no side effects.

Reset
REQ-029 On nrst low, immediately: gpio_out=0, FIFO empty (count 0, tx_valid=0, tx_data=0), overflow=0, err_misaligned=0, cycle counter=0; RAM contents not reset; reset mid-FIFO-drain discards all entries.

Configuration
REQ-030 Macro MEM_SUBSYS_CYCLE_COUNTER_EN defined: CYCLE increments by 1 every cycle, wraps 0xFFFFFFFF->0; a write to CYCLE loads 0, taking priority over the increment.
REQ-031 Macro MEM_SUBSYS_CYCLE_COUNTER_EN undefined: no counter logic; CYCLE reads 0; writes ignored.

Verification
REQ-032 Write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> rdata=0xDEADBEEF; same-cycle read/write of 0x10 with 0x12345678 -> rdata=0xDEADBEEF, later read 0x12345678.
REQ-033 tx_ready=0; push 1,2,3,4,5 -> STATUS=0x11 then 0x31 (full, count 4, overflow); tx_ready=1 -> tx_data 1,2,3,4 on successive cycles, then tx_valid=0.
REQ-034 FIFO full with tx_ready=1 and push of 9 in the same cycle -> count stays 4; word 9 emerges after the 3 older entries.
REQ-035 Write 0x000000A5 to 0xF0000000 -> gpio_out=0xA5; write to 0x00000012 -> RAM word 4 unchanged, err_misaligned=1; nrst pulse -> gpio_out=0, err_misaligned=0.
REQ-036 With macro defined: write CYCLE, read 10 cycles later -> 10; preset counter to 0xFFFFFFFF -> wraps to 0; without macro -> CYCLE always reads 0.
